systimer_tick_gen: RTL and testbench
====================================

// Module: systimer_tick_gen
// PURPOSE
//  Generates the systemtimer_clk consumed by the machine system timer (mtime increments once per rising edge).
//  - Integer divide of hb_clk, output from a register, glitch-free; period never below 4 hb_clk cycles
//    (timer clock must be more than 2x slower than hb_clk).
//  - Software-programmable through the system-peripheral bus: enable, divisor, status.
// PARAMETERS
//  DIV_W      16  width of divisor register/counter
//  RESET_DIV  24  divisor after reset (hb_clk cycles per tick), must be >= 4
//  RESET_EN   1   enable bit value after reset
// PORTS
//  hb_clk           in   1   high-speed bus clock; the only clock
//  hb_rst           in   1   asynchronous, active-high reset
//  sys_share        in   sys_peripheral_t  shared raddr/waddr/wdata
//  sel              in   sel_t  this block's wen/ren strobes
//  rdata            out  32  registered read data
//  systemtimer_clk  out  1   divided timer clock to system timer
//  period_end       out  1   1-cycle pulse, asserted with each systemtimer_clk rising edge
// BEHAVIOUR
//  Reset (async, hb_rst=1): systemtimer_clk=0, period_end=0, rdata=0, cnt=0, div_act=div_reg=RESET_DIV,
//    en=RESET_EN, pend=0. First rising edge 1 cycle after reset release when RESET_EN=1.
//  Registers (word addr):
//    0 CTRL   [0] EN rw; [1] RESTART wo, reads 0
//    1 DIV    [DIV_W-1:0] rw; write <4 stores 4; upper bits ignored, read 0
//    2 STATUS [0] running(=en) ro; [1] pend (DIV written, not yet active) ro
//    3 FRAC   see CONFIGURATION; others: read 0, write ignored
//  Reads: rdata updated on the edge where sel.ren=1 (1-cycle latency), else holds.
//  Counter: cnt runs 0..div_act-1 while en; half=div_act>>1.
//    Each edge: systemtimer_clk <= en && (cnt < half); cnt <= (cnt==div_act-1) ? 0 : cnt+1.
//    High phase = floor(D/2) cycles, low = D-floor(D/2); D=5 -> 2 high, 3 low.
//    period_end <= en && cnt==0 (coincides with systemtimer_clk 0->1).
//  DIV write while en=1: goes to div_reg, pend=1; div_act<=div_reg at wrap (cnt==div_act-1), pend cleared.
//    No shortened/stretched period ever emitted.
//  DIV write while en=0: div_act and div_reg load same cycle, pend stays 0.
//  EN 1->0: cnt=0, systemtimer_clk=0, period_end=0 on that edge (a high phase is truncated, no extra edge).
//  EN 0->1 (write at edge T): cnt=0 at T; rising edge at T+1.
//  RESTART=1 with EN=1: cnt=0, systemtimer_clk forced 0 at edge T; next rising edge at T+1;
//    pending DIV applied immediately.
//  Simultaneous: DIV write and wrap in same cycle -> new value applied at wrap (write wins over pend).
//    CTRL write EN=0 at wrap -> disable wins, no period_end.
//  Write to DIV with EN=0 and RESTART in same bus word impossible (separate addrs); no ordering issue.
// CONFIGURATION
//  SYSTIMER_TICK_FRAC_EN defined:
//    Adds FRAC reg (addr 3, [7:0] rw, reset 0) + 8-bit phase accumulator acc.
//    At each wrap acc<=acc+FRAC; on carry out the next period is div_act+1 cycles (extra cycle in low phase).
//    Average period = div_act + FRAC/256. FRAC write takes effect at next wrap; acc cleared by EN 1->0,
//    RESTART, reset.
//  Undefined: addr 3 reads 0, writes ignored; all periods exactly div_act.
// TESTING
//  1 Reset, RESET_DIV=24, RESET_EN=1 -> period 24 cycles, 12 high/12 low, period_end 1 cycle at each rise.
//  2 Write DIV=5 mid-period -> STATUS=0x3 until wrap; current period stays 24; then 2 high/3 low; STATUS=0x1.
//  3 Write DIV=1, then DIV=0 -> readback 4 both times; output 2 high/2 low.
//  4 Assert EN=0 during high phase -> output low next edge, no period_end; EN=1 at edge T -> rise at T+1.
//  5 hb_rst pulsed mid-high phase -> output 0 immediately (async); state back to reset values.
//  6 (FRAC_EN) DIV=10, FRAC=0x40 -> every 4th period is 11 cycles; 256 periods = 2560+64 cycles.
//    (no FRAC_EN) addr 3 reads 0.

Source files
------------

// File: rtl/systimer_tick_gen.sv
// systimer_tick_gen: divides hb_clk down to systemtimer_clk for the machine
// system timer, programmed over the system-peripheral bus.
// Optional build macro: SYSTIMER_TICK_FRAC_EN adds the FRAC register (addr 3)
// and an 8-bit phase accumulator that stretches a period by one cycle on carry.
// Bus handshake: a write is taken on every hb_clk edge where sel.wen=1 (no
// back-pressure); a read is taken on every edge where sel.ren=1 and rdata holds
// the result from the following cycle until the next read.

package systimer_tick_gen_pkg;
  typedef struct packed {
    logic [3:0]  raddr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
  } sys_peripheral_t;

  typedef struct packed {
    logic wen;
    logic ren;
  } sel_t;
endpackage

module systimer_tick_gen
  import systimer_tick_gen_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 24,
  parameter bit RESET_EN  = 1'b1
) (
  input  logic            hb_clk,
  input  logic            hb_rst,
  input  sys_peripheral_t sys_share,
  input  sel_t            sel,
  output logic [31:0]     rdata,
  output logic            systemtimer_clk,
  output logic            period_end
);

  localparam logic [3:0]       ADDR_CTRL   = 4'd0;
  localparam logic [3:0]       ADDR_DIV    = 4'd1;
  localparam logic [3:0]       ADDR_STATUS = 4'd2;
  localparam logic [3:0]       ADDR_FRAC   = 4'd3;
  localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(4);
  localparam logic [DIV_W-1:0] RST_DIV     = DIV_W'(RESET_DIV);

  logic             en;
  logic             pend;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_last;
  logic [DIV_W-1:0] div_wval;
  logic             wrap;
  logic             wr_ctrl;
  logic             wr_div;
  logic             disable_evt;
  logic             restart_evt;
  logic             apply_now;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign wr_ctrl = sel.wen && (sys_share.waddr == ADDR_CTRL);
  assign wr_div  = sel.wen && (sys_share.waddr == ADDR_DIV);

  // Divisors below 4 would let the timer clock run too close to hb_clk.
  assign div_wval = (sys_share.wdata[DIV_W-1:0] < MIN_DIV) ? MIN_DIV
                                                           : sys_share.wdata[DIV_W-1:0];

  // Clearing EN always stops the counter; setting EN from off, or RESTART with
  // EN, rewinds the counter so the next edge is a rising edge.
  assign disable_evt = wr_ctrl && !sys_share.wdata[0];
  assign restart_evt = wr_ctrl && sys_share.wdata[0] && (sys_share.wdata[1] || !en);

  assign unused_wdata = ^sys_share.wdata[31:DIV_W];

`ifdef SYSTIMER_TICK_FRAC_EN
  logic       wr_frac;
  logic [7:0] frac_reg;
  logic [7:0] acc;
  logic       extra;

  assign wr_frac = sel.wen && (sys_share.waddr == ADDR_FRAC);

  // Phase accumulator: a carry at wrap adds one low-phase cycle to the next period.
  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      frac_reg <= 8'd0;
      acc      <= 8'd0;
      extra    <= 1'b0;
    end else begin
      if (wr_frac) frac_reg <= sys_share.wdata[7:0];
      if (disable_evt || restart_evt) begin
        acc   <= 8'd0;
        extra <= 1'b0;
      end else if (en && wrap) begin
        {extra, acc} <= {1'b0, acc} + {1'b0, frac_reg};
      end
    end
  end
`else
  logic extra;
  assign extra = 1'b0;
`endif

  assign half     = div_act >> 1;
  assign cnt_last = extra ? div_act : (div_act - DIV_W'(1));
  assign wrap     = (cnt == cnt_last);

  // A new divisor may only take over when no period is in flight.
  assign apply_now = !en || disable_evt || restart_evt || wrap;

  // Enable, counter and registered clock/pulse outputs.
  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      en              <= RESET_EN;
      cnt             <= '0;
      systemtimer_clk <= 1'b0;
      period_end      <= 1'b0;
    end else begin
      if (wr_ctrl) en <= sys_share.wdata[0];
      if (disable_evt || restart_evt || !en) begin
        cnt             <= '0;
        systemtimer_clk <= 1'b0;
        period_end      <= 1'b0;
      end else begin
        systemtimer_clk <= (cnt < half);
        period_end      <= (cnt == '0);
        cnt             <= wrap ? '0 : (cnt + DIV_W'(1));
      end
    end
  end

  // Divisor staging: programmed value in div_reg, active value swapped in at a safe point.
  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      div_reg <= RST_DIV;
      div_act <= RST_DIV;
      pend    <= 1'b0;
    end else if (wr_div) begin
      div_reg <= div_wval;
      if (apply_now) begin
        div_act <= div_wval;
        pend    <= 1'b0;
      end else begin
        pend    <= 1'b1;
      end
    end else if (pend && apply_now) begin
      div_act <= div_reg;
      pend    <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    rd_val = 32'd0;
    case (sys_share.raddr)
      ADDR_CTRL:   rd_val = {31'd0, en};
      ADDR_DIV:    rd_val = 32'(div_reg);
      ADDR_STATUS: rd_val = {30'd0, pend, en};
`ifdef SYSTIMER_TICK_FRAC_EN
      ADDR_FRAC:   rd_val = {24'd0, frac_reg};
`endif
      default:     rd_val = 32'd0;
    endcase
  end

  // Read data register: loads on a read strobe, otherwise holds.
  always_ff @(posedge hb_clk or posedge hb_rst) begin
    if (hb_rst) begin
      rdata <= 32'd0;
    end else if (sel.ren) begin
      rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_systimer_tick_gen.sv
// Testbench for systimer_tick_gen: bus reads and timer periods are checked by
// monitors against expected queues filled by the stimulus.
module tb_systimer_tick_gen;
  import systimer_tick_gen_pkg::*;

  logic            hb_clk = 1'b0;
  logic            hb_rst;
  sys_peripheral_t sys_share;
  sel_t            sel;
  logic [31:0]     rdata;
  logic            systemtimer_clk;
  logic            period_end;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];   // expected rdata values
  logic [31:0] per_q[$];   // expected {high[15:0], period[15:0]}

  // ---------------- clock / reset ----------------
  always #5 hb_clk = ~hb_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  systimer_tick_gen #(.DIV_W(16), .RESET_DIV(24), .RESET_EN(1'b1)) dut (
    .hb_clk          (hb_clk),
    .hb_rst          (hb_rst),
    .sys_share       (sys_share),
    .sel             (sel),
    .rdata           (rdata),
    .systemtimer_clk (systemtimer_clk),
    .period_end      (period_end)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sys_share.waddr = a;
    sys_share.wdata = d;
    sel.wen = 1'b1;
    @(posedge hb_clk);
    #1;
    sel.wen = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e);
    sys_share.raddr = a;
    sel.ren = 1'b1;
    exp_q.push_back(e);
    @(posedge hb_clk);
    #1;
    sel.ren = 1'b0;
  endtask

  bit arm = 1'b0;
  bit rearm = 1'b0;

  task automatic arm_on();
    per_q.delete();
    arm = 1'b1;
    rearm = 1'b1;
  endtask

  task automatic push_per(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) per_q.push_back({hi[15:0], per[15:0]});
  endtask

  task automatic wait_per(input int budget);
    int n = 0;
    while (per_q.size() > 0 && n < budget) begin
      @(negedge hb_clk);
      #1;
      n++;
    end
    check("periods_outstanding", per_q.size(), 0);
    per_q.delete();
  endtask

  task automatic wait_rise(input int budget);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < budget) begin
      @(negedge hb_clk);
      n++;
      if (period_end === 1'b1) got = 1'b1;
    end
    check("rise_wait", got, 1);
  endtask

  // ---------------- read-data monitor ----------------
  logic rd_v = 1'b0;
  always @(posedge hb_clk) rd_v = sel.ren;

  always @(negedge hb_clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) check("rdata_unexpected", rdata, 32'hDEAD_BEEF);
      else check("rdata", rdata, exp_q.pop_front());
    end
  end

  // ---------------- timer-clock monitor ----------------
  int          cyc = 0;
  int          last_rise = 0;
  bit          have_last = 1'b0;
  int          hi_acc = 0;
  logic        stc_d = 1'b0;
  logic        mon_rise;
  logic [31:0] mon_e;

  always @(negedge hb_clk) begin
    cyc++;
    mon_rise = (systemtimer_clk === 1'b1) && (stc_d !== 1'b1);
    check("period_end_vs_rise", period_end, mon_rise);
    if (mon_rise) begin
      if (rearm) begin
        have_last = 1'b0;
        rearm = 1'b0;
      end
      if (arm && have_last && per_q.size() > 0) begin
        mon_e = per_q.pop_front();
        check("period_len", cyc - last_rise, {16'd0, mon_e[15:0]});
        check("high_len", hi_acc, {16'd0, mon_e[31:16]});
      end
      last_rise = cyc;
      have_last = 1'b1;
      hi_acc = 0;
    end
    if (systemtimer_clk === 1'b1) hi_acc++;
    stc_d = systemtimer_clk;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    sys_share = '0;
    sel = '0;
    hb_rst = 1'b0;
    #1 hb_rst = 1'b1;

    // 1: reset values, then 24-cycle periods with 12 high
    repeat (3) @(posedge hb_clk);
    #1;
    check("rst_stc", systemtimer_clk, 0);
    check("rst_pe", period_end, 0);
    check("rst_rdata", rdata, 0);
    arm_on();
    push_per(12, 24, 3);
    @(negedge hb_clk);
    hb_rst = 1'b0;
    @(posedge hb_clk);
    #1;
    check("first_rise_stc", systemtimer_clk, 1);
    check("first_rise_pe", period_end, 1);
    bus_read(4'd0, 32'h1);
    bus_read(4'd1, 32'd24);
    bus_read(4'd2, 32'h1);
    wait_per(100);

    // 2: DIV=5 mid-period, current period unchanged, then 2 high / 3 low
    push_per(12, 24, 1);
    push_per(2, 5, 3);
    bus_write(4'd1, 32'd5);
    bus_read(4'd2, 32'h3);
    bus_read(4'd1, 32'd5);
    wait_per(120);
    bus_read(4'd2, 32'h1);

    // 3: DIV below minimum clamps to 4
    arm = 1'b0;
    bus_write(4'd1, 32'd1);
    bus_read(4'd1, 32'd4);
    bus_write(4'd1, 32'd0);
    bus_read(4'd1, 32'd4);
    repeat (12) @(posedge hb_clk);
    #1;
    bus_read(4'd2, 32'h1);
    arm_on();
    push_per(2, 4, 3);
    wait_per(40);

    // 4: disable during high phase, re-enable rises one edge later
    arm = 1'b0;
    wait_rise(20);
    bus_write(4'd0, 32'h0);
    check("dis_stc_low", systemtimer_clk, 0);
    check("dis_pe_low", period_end, 0);
    repeat (5) @(posedge hb_clk);
    #1;
    check("dis_stays_low", systemtimer_clk, 0);
    bus_read(4'd2, 32'h0);
    bus_write(4'd0, 32'h1);
    check("en_edge_stc", systemtimer_clk, 0);
    @(posedge hb_clk);
    #1;
    check("en_next_stc", systemtimer_clk, 1);
    check("en_next_pe", period_end, 1);
    arm_on();
    push_per(2, 4, 2);
    wait_per(30);

    // restart with a pending divisor applies it immediately
    arm = 1'b0;
    wait_rise(20);
    bus_write(4'd1, 32'd6);
    bus_write(4'd0, 32'h3);
    check("rs_stc", systemtimer_clk, 0);
    check("rs_pe", period_end, 0);
    arm_on();
    @(posedge hb_clk);
    #1;
    check("rs_next_stc", systemtimer_clk, 1);
    check("rs_next_pe", period_end, 1);
    push_per(3, 6, 2);
    wait_per(30);
    bus_read(4'd2, 32'h1);
    bus_read(4'd1, 32'd6);

    // 5: async reset in high phase
    arm = 1'b0;
    wait_rise(20);
    #2;
    hb_rst = 1'b1;
    #1;
    check("async_rst_stc", systemtimer_clk, 0);
    check("async_rst_pe", period_end, 0);
    check("async_rst_rdata", rdata, 0);
    @(negedge hb_clk);
    hb_rst = 1'b0;
    arm_on();
    push_per(12, 24, 2);
    bus_read(4'd1, 32'd24);
    bus_read(4'd2, 32'h1);
    bus_read(4'd0, 32'h1);
    wait_per(80);

    // 6: FRAC register
`ifdef SYSTIMER_TICK_FRAC_EN
    arm = 1'b0;
    bus_write(4'd1, 32'd10);
    bus_write(4'd3, 32'h40);
    bus_read(4'd3, 32'h40);
    bus_write(4'd0, 32'h3);
    arm_on();
    push_per(5, 10, 4);
    push_per(5, 11, 1);
    push_per(5, 10, 3);
    push_per(5, 11, 1);
    wait_per(140);
`else
    bus_write(4'd3, 32'hFF);
    bus_read(4'd3, 32'h0);
    bus_read(4'hA, 32'h0);
`endif

    repeat (3) @(posedge hb_clk);
    #1;
    check("rdata_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
